// File: rtl/rf_wb_queue.sv
// In-order write-back queue feeding the register file's single write port.
// Define WB_BYPASS_EN to build the forwarding search over queued entries.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_regsel,
    input  logic [DW-1:0]              in_data,
    input  logic                       hold,
    output logic                       write,
    output logic [AW-1:0]              writeregsel,
    output logic [DW-1:0]              writedata,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [AW-1:0]              fwd_sel,
    output logic                       fwd_hit,
    output logic [DW-1:0]              fwd_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] sel_q;
    logic [DEPTH-1:0][DW-1:0] dat_q;
    logic [PW-1:0]            rd_q, rd_d;
    logic [PW-1:0]            wr_q, wr_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     push, pop;

    // A full queue refuses input even when it drains this cycle.
    assign in_ready    = (cnt_q != CW'(DEPTH));
    assign write       = (cnt_q != '0) & ~hold;
    assign writeregsel = sel_q[rd_q];
    assign writedata   = dat_q[rd_q];
    assign count       = cnt_q;

    assign push = in_valid & in_ready;
    assign pop  = write;

    always_comb begin
        rd_d  = pop  ? rd_q + 1'b1 : rd_q;
        wr_d  = push ? wr_q + 1'b1 : wr_q;
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (!push && pop)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            dat_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                sel_q[wr_q] <= in_regsel;
                dat_q[wr_q] <= in_data;
            end
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef WB_BYPASS_EN
    logic          fwd_hit_c;
    logic [DW-1:0] fwd_data_c;

    // Scan oldest to youngest so the youngest match overwrites earlier ones;
    // the head stays visible during its drain cycle since cnt_q has not yet dropped.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < cnt_q) && (sel_q[rd_q + PW'(i)] == fwd_sel)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = dat_q[rd_q + PW'(i)];
            end
        end
    end

    assign fwd_hit  = fwd_hit_c;
    assign fwd_data = fwd_data_c;
`else
    // Without forwarding the read stage waits for count == 0 instead.
    logic unused_fwd_sel;
    assign unused_fwd_sel = ^fwd_sel;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: doc/rf_wb_queue.md
# rf_wb_queue

Write-back queue sitting in front of the 8 x 16-bit register file's single write port. Accepts result write requests from the execute/memory stage, buffers them in order in a small FIFO and drains one entry per cycle onto the register file's `write` / `writeregsel` / `writedata` port. An optional forwarding port lets the operand-read stage see values that are queued but not yet written.

## Interface
Parameters:
- `DEPTH`, 4, number of queue entries (power of two, >= 2)
- `DW`, 16, data width, matches register width
- `AW`, 3, register-select width (8 registers)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  producer presents a write request
- `in_ready`  out  1  queue can accept a request this cycle
- `in_regsel`  in  AW  destination register of the request
- `in_data`  in  DW  value to write
- `hold`  in  1  suppresses draining this cycle
- `write`  out  1  register-file write enable
- `writeregsel`  out  AW  register-file write select
- `writedata`  out  DW  register-file write data
- `count`  out  log2(DEPTH)+1  number of occupied entries
- `fwd_sel`  in  AW  register being looked up by the read stage
- `fwd_hit`  out  1  a queued entry targets `fwd_sel`
- `fwd_data`  out  DW  value of the youngest matching queued entry

## Operation
- Circular buffer: `DEPTH` entries of {regsel, data}; read pointer, write pointer, occupancy counter of width log2(DEPTH)+1.
- Enqueue: `in_valid & in_ready` at an edge stores {in_regsel, in_data} at the write pointer, which then advances modulo `DEPTH`.
- `in_ready = (count != DEPTH)`. No pass-through: a full queue refuses input even if it drains in the same cycle.
- Drain: `write = (count != 0) & ~hold`; `writeregsel` and `writedata` are combinational from the head entry. On an edge with `write` high, the read pointer advances modulo `DEPTH`.
- Simultaneous enqueue and drain: `count` unchanged, both pointers advance.
- Multiple queued writes to the same register drain in arrival order. The last one wins in the register file.
- Forwarding (when compiled in): combinational search over occupied entries only. The youngest entry whose regsel equals `fwd_sel` drives `fwd_data` with `fwd_hit = 1`. The head entry counts as pending during the cycle it drains. `in_data` of a not-yet-accepted request is never forwarded.
- No hit: `fwd_hit = 0`, `fwd_data = 0`.

## Timing
- Reset (async, immediate): pointers = 0, `count` = 0, all entry contents = 0.
- Reset values of outputs: `write` = 0, `writeregsel` = 0, `writedata` = 0, `in_ready` = 1, `fwd_hit` = 0, `fwd_data` = 0.
- Latency: a request accepted at edge N into an empty queue with `hold` low drives `write` = 1 during cycle N..N+1. The register file captures it at edge N+1.
- Throughput: one enqueue and one drain per cycle.
- Hold behaviour: `hold` high freezes the read pointer and holds `write` low. Queue contents are preserved and enqueue continues until full.
- Pointer wrap: the pointer following `DEPTH-1` is 0, with no bubble.
- Reset asserted mid-operation discards all queued entries. Nothing is written after reset.

## Configuration
- `WB_BYPASS_EN` defined: the forwarding search logic is present as described.
- `WB_BYPASS_EN` undefined:
  - `fwd_hit` and `fwd_data` are tied to 0 and no compare logic is built.
  - `fwd_sel` is unused.
  - The read stage must stall until `count` = 0.

## Test plan
- Reset, then idle: `write` = 0, `count` = 0, `in_ready` = 1. Assert `rst` asynchronously mid-cycle with 2 entries queued: `count` goes to 0 immediately and `write` goes to 0.
- Single request {3, 16'hBEEF} into an empty queue: next cycle `write` = 1, `writeregsel` = 3, `writedata` = 16'hBEEF; one cycle later `count` = 0.
- Hold high, enqueue 5 requests with DEPTH = 4: the 5th is refused (`in_ready` = 0 at `count` = 4). Release hold: entries drain in order over 4 cycles, then `write` = 0.
- Continuous stream of 10 requests with `hold` low: accepted and drained back-to-back, pointers wrap twice, `count` stays at 1, and register-file contents match the last value per register.
- Forwarding (`WB_BYPASS_EN`), hold high: queue {2, 16'h0011}, {5, 16'h0022}, {2, 16'h0033}. `fwd_sel` = 2 gives hit with 16'h0033; `fwd_sel` = 5 gives 16'h0022; `fwd_sel` = 7 gives hit = 0, data = 0.
- Build without `WB_BYPASS_EN`, same stimulus: `fwd_hit` = 0 and `fwd_data` = 0 throughout; drain behaviour is unchanged.
